icache_fill_ctrl: RTL and testbench

- Miss-handling and refill controller that directly drives the 2-way, 64-set, 8-word-per-line instruction cache array.
- Performs lookup on the fetch address using the cache's two metadata read ports.
- On a miss: stalls fetch, streams one 8-word line from the 4-cycle pipelined memory, writes each word into the victim way, then rewrites both ways' metadata.
- Metadata byte format: bit7 valid, bit6 LRU (1 = this way is next victim), bits5:0 tag.

---
 rtl/icache_fill_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: lookup, miss refill and metadata rewrite for a 2-way, 64-set, 8-word-line icache.
// Optional macro ICACHE_LRU_ON_HIT_EN: an IDLE hit on the LRU-marked way rewrites both ways' metadata.
module icache_fill_ctrl #(
    parameter int TAG_W = 6,
    parameter int SET_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [15:0]          req_addr,
    input  logic [7:0]           meta_rd1,
    input  logic [7:0]           meta_rd2,
    input  logic [15:0]          mem_data_in,
    input  logic                 mem_data_valid,
    output logic                 stall,
    output logic                 cache_hit,
    output logic                 hit_way2,
    output logic                 mem_en,
    output logic [15:0]          mem_addr,
    output logic [7:0]           meta_in,
    output logic [15:0]          data_in,
    output logic [2**SET_W-1:0]  block_en,
    output logic [7:0]           word_en,
    output logic                 meta_write1,
    output logic                 meta_write2,
    output logic                 data_write1,
    output logic                 data_write2,
    output logic                 fill_busy
);
    localparam int NSETS = 2**SET_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        META_V = 2'd2,
        META_O = 2'd3
    } state_t;

    state_t             state_r, nextState_s;
    logic [TAG_W-1:0]   tag_r;
    logic [SET_W-1:0]   set_r;
    logic               victimWay2_r;
    logic               otherValid_r;
    logic [TAG_W-1:0]   otherTag_r;
    logic [3:0]         issCnt_r;
    logic [3:0]         rcvCnt_r;

    logic [TAG_W-1:0]   reqTag_s;
    logic [SET_W-1:0]   reqSet_s;
    logic [2:0]         reqWord_s;
    logic               hit1_s;
    logic               hit2_s;
    logic               victimSelWay2_s;
    logic               capture_s;
    logic               captureWay2_s;
    logic               unusedAddrBit_s;

    function automatic logic [NSETS-1:0] setOneHot(input logic [SET_W-1:0] idx);
        logic [NSETS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] wordOneHot(input logic [2:0] idx);
        logic [7:0] v;
        v      = 8'h00;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign reqTag_s        = req_addr[15 -: TAG_W];
    assign reqSet_s        = req_addr[SET_W+3:4];
    assign reqWord_s       = req_addr[3:1];
    assign unusedAddrBit_s = req_addr[0];
    assign hit1_s          = meta_rd1[7] & (meta_rd1[TAG_W-1:0] == reqTag_s);
    assign hit2_s          = meta_rd2[7] & (meta_rd2[TAG_W-1:0] == reqTag_s);

    // Replacement choice: fill an invalid way first, then the way flagged as next victim.
    always_comb begin
        if (!meta_rd1[7]) begin
            victimSelWay2_s = 1'b0;
        end else if (!meta_rd2[7]) begin
            victimSelWay2_s = 1'b1;
        end else if (meta_rd1[6]) begin
            victimSelWay2_s = 1'b0;
        end else if (meta_rd2[6]) begin
            victimSelWay2_s = 1'b1;
        end else begin
            victimSelWay2_s = 1'b0;
        end
    end

    // Next-state and array-control decode; reset forces every control low.
    always_comb begin
        nextState_s   = state_r;
        stall         = 1'b0;
        cache_hit     = 1'b0;
        hit_way2      = 1'b0;
        mem_en        = 1'b0;
        mem_addr      = 16'h0000;
        meta_in       = 8'h00;
        data_in       = 16'h0000;
        block_en      = setOneHot(reqSet_s);
        word_en       = 8'h00;
        meta_write1   = 1'b0;
        meta_write2   = 1'b0;
        data_write1   = 1'b0;
        data_write2   = 1'b0;
        fill_busy     = 1'b0;
        capture_s     = 1'b0;
        captureWay2_s = 1'b0;
        if (rst) begin
            nextState_s = IDLE;
        end else begin
            data_in = mem_data_in;
            case (state_r)
                IDLE: begin
                    word_en   = wordOneHot(reqWord_s);
                    cache_hit = req_valid & (hit1_s | hit2_s);
                    hit_way2  = req_valid & hit2_s & ~hit1_s;
                    if (req_valid & ~(hit1_s | hit2_s)) begin
                        stall         = 1'b1;
                        capture_s     = 1'b1;
                        captureWay2_s = victimSelWay2_s;
                        nextState_s   = FILL;
                    end
`ifdef ICACHE_LRU_ON_HIT_EN
                    else if (req_valid & ((hit1_s & meta_rd1[6]) | (hit2_s & ~hit1_s & meta_rd2[6]))) begin
                        capture_s     = 1'b1;
                        captureWay2_s = hit2_s & ~hit1_s;
                        nextState_s   = META_V;
                    end
`endif
                    else begin
                        nextState_s = IDLE;
                    end
                end
                FILL: begin
                    stall     = 1'b1;
                    fill_busy = 1'b1;
                    block_en  = setOneHot(set_r);
                    word_en   = wordOneHot(rcvCnt_r[2:0]);
                    if (issCnt_r < 4'd8) begin
                        mem_en   = 1'b1;
                        mem_addr = {tag_r, set_r, issCnt_r[2:0], 1'b0};
                    end else begin
                        mem_en   = 1'b0;
                    end
                    if (mem_data_valid && (rcvCnt_r < 4'd8)) begin
                        data_write1 = ~victimWay2_r;
                        data_write2 = victimWay2_r;
                        if (rcvCnt_r == 4'd7) begin
                            nextState_s = META_V;
                        end else begin
                            nextState_s = FILL;
                        end
                    end else begin
                        nextState_s = FILL;
                    end
                end
                META_V: begin
                    stall       = 1'b1;
                    fill_busy   = 1'b1;
                    block_en    = setOneHot(set_r);
                    meta_in     = {1'b1, 1'b0, tag_r};
                    meta_write1 = ~victimWay2_r;
                    meta_write2 = victimWay2_r;
                    nextState_s = META_O;
                end
                META_O: begin
                    stall       = 1'b1;
                    fill_busy   = 1'b1;
                    block_en    = setOneHot(set_r);
                    meta_in     = {otherValid_r, 1'b1, otherTag_r};
                    meta_write1 = victimWay2_r;
                    meta_write2 = ~victimWay2_r;
                    nextState_s = IDLE;
                end
                default: begin
                    nextState_s = IDLE;
                end
            endcase
        end
    end

    // State, latched line identity and issue/receive counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            tag_r        <= '0;
            set_r        <= '0;
            victimWay2_r <= 1'b0;
            otherValid_r <= 1'b0;
            otherTag_r   <= '0;
            issCnt_r     <= 4'd0;
            rcvCnt_r     <= 4'd0;
        end else begin
            state_r <= nextState_s;
            if (capture_s) begin
                tag_r        <= reqTag_s;
                set_r        <= reqSet_s;
                victimWay2_r <= captureWay2_s;
                otherValid_r <= captureWay2_s ? meta_rd1[7] : meta_rd2[7];
                otherTag_r   <= captureWay2_s ? meta_rd1[TAG_W-1:0] : meta_rd2[TAG_W-1:0];
            end
            if (state_r == FILL) begin
                if (issCnt_r < 4'd8) begin
                    issCnt_r <= issCnt_r + 4'd1;
                end
                if (mem_data_valid && (rcvCnt_r < 4'd8)) begin
                    rcvCnt_r <= rcvCnt_r + 4'd1;
                end
            end else begin
                issCnt_r <= 4'd0;
                rcvCnt_r <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: emulates the cache array and a 4-cycle pipelined memory, and checks
// every cycle against a transaction-level model of lookups, refills and metadata updates.
module tb_icache_fill_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, mem_data_valid, strayValid;
    logic [15:0] req_addr, mem_data_in, mem_addr, data_in;
    logic [7:0]  meta_rd1, meta_rd2, meta_in, word_en;
    logic [63:0] block_en;
    logic        stall, cache_hit, hit_way2, mem_en;
    logic        meta_write1, meta_write2, data_write1, data_write2, fill_busy;

    icache_fill_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .meta_rd1(meta_rd1), .meta_rd2(meta_rd2),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .stall(stall), .cache_hit(cache_hit), .hit_way2(hit_way2),
        .mem_en(mem_en), .mem_addr(mem_addr), .meta_in(meta_in), .data_in(data_in),
        .block_en(block_en), .word_en(word_en),
        .meta_write1(meta_write1), .meta_write2(meta_write2),
        .data_write1(data_write1), .data_write2(data_write2), .fill_busy(fill_busy)
    );

    function automatic logic [15:0] memFn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [5:0] ohSet(input logic [63:0] v);
        logic [5:0] r;
        r = 6'd0;
        for (int i = 0; i < 64; i++) if (v[i]) r = i[5:0];
        return r;
    endfunction

    function automatic logic [2:0] ohWord(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i[2:0];
        return r;
    endfunction

    // Cache array emulation, driven only by the DUT's write controls
    logic [7:0]  arrMeta1 [64] = '{default: 8'h00};
    logic [7:0]  arrMeta2 [64] = '{default: 8'h00};
    logic [15:0] arrData1 [64][8] = '{default: '{default: 16'h0000}};
    logic [15:0] arrData2 [64][8] = '{default: '{default: 16'h0000}};
    assign meta_rd1 = arrMeta1[req_addr[9:4]];
    assign meta_rd2 = arrMeta2[req_addr[9:4]];

    always @(posedge clk) begin
        if (meta_write1) arrMeta1[ohSet(block_en)] <= meta_in;
        if (meta_write2) arrMeta2[ohSet(block_en)] <= meta_in;
        if (data_write1) arrData1[ohSet(block_en)][ohWord(word_en)] <= data_in;
        if (data_write2) arrData2[ohSet(block_en)][ohWord(word_en)] <= data_in;
    end

    // Memory: data for a request accepted in cycle k is returned in cycle k+4
    logic [3:0]  pv = 4'h0;
    logic [15:0] pa [4] = '{default: 16'h0000};
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign mem_data_valid = pv[3] | strayValid;
    assign mem_data_in    = strayValid ? 16'hDEAD : memFn(pa[3]);

    // Reference model of cache contents
    logic       refV   [2][64];
    logic       refLru [2][64];
    logic [5:0] refTag [2][64];

    // Expected outputs for the current cycle
    logic        eStall, eHit, eHw2, eMemEn, eMw1, eMw2, eDw1, eDw2, eBusy, ckWord;
    logic [15:0] eMemAddr, eDataIn;
    logic [7:0]  eMetaIn, eWordEn;
    logic [63:0] eBlockEn;
    int          nChecks = 0;
    int          nPass = 0;
    int          cyc = 0;

    task automatic compare(input string ph);
        logic [120:0] act, expv, msk;
        act  = {stall, cache_hit, hit_way2, mem_en, mem_addr, meta_write1, meta_write2, meta_in,
                data_write1, data_write2, word_en, data_in, fill_busy, block_en};
        expv = {eStall, eHit, eHw2, eMemEn, eMemAddr, eMw1, eMw2, eMetaIn,
                eDw1, eDw2, eWordEn, eDataIn, eBusy, eBlockEn};
        msk  = {4'hF, {16{eMemEn}}, 2'b11, {8{eMw1 | eMw2}}, 2'b11, {8{ckWord}},
                {16{eDw1 | eDw2}}, 1'b1, {64{1'b1}}};
        nChecks++;
        if (((act ^ expv) & msk) !== 121'd0)
            $display("FAIL %s cyc=%0d got=%h want=%h care=%h", ph, cyc, act, expv, msk);
        else
            nPass++;
    endtask

    task automatic checkLit(input string nm, input logic [15:0] got, input logic [15:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("FAIL %s got=%h want=%h", nm, got, want);
    endtask

    task automatic tick(input string ph);
        @(negedge clk);
        compare(ph);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic setIdle(input logic [15:0] a);
        eStall = 1'b0; eHit = 1'b0; eHw2 = 1'b0; eMemEn = 1'b0; eMemAddr = 16'h0000;
        eMw1 = 1'b0; eMw2 = 1'b0; eMetaIn = 8'h00; eDw1 = 1'b0; eDw2 = 1'b0;
        eDataIn = 16'h0000; eBusy = 1'b0;
        eBlockEn = 64'h1 << a[9:4];
        eWordEn  = 8'h01 << a[2:0] >> 0;
        eWordEn  = 8'h01 << a[3:1];
        ckWord   = 1'b1;
    endtask

    // One request: a hit is one cycle; a miss is the 15-cycle refill (optionally aborted by reset at cycle abortK)
    task automatic access(input logic [15:0] a, input int abortK);
        logic [5:0] t, s;
        logic [2:0] wk;
        int hw, v, o;
        t = a[15:10];
        s = a[9:4];
        hw = -1;
        if (refV[0][s] && refTag[0][s] == t) hw = 0;
        else if (refV[1][s] && refTag[1][s] == t) hw = 1;
        req_valid = 1'b1;
        req_addr  = a;
        if (hw >= 0) begin
            setIdle(a);
            eHit = 1'b1;
            eHw2 = (hw == 1);
            tick("hit");
        end else begin
            if (!refV[0][s]) v = 0;
            else if (!refV[1][s]) v = 1;
            else if (refLru[0][s]) v = 0;
            else if (refLru[1][s]) v = 1;
            else v = 0;
            o = 1 - v;
            for (int k = 0; k < 15; k++) begin
                setIdle(a);
                if (k == abortK) begin
                    rst = 1'b1;
                    req_valid = 1'b0;
                    eWordEn = 8'h00;
                    tick("rst_fill");
                    rst = 1'b0;
                    return;
                end
                ckWord = (k == 0);
                eStall = 1'b1;
                eBusy  = (k > 0);
                if (k >= 1 && k <= 8) begin
                    wk = 3'(k - 1);
                    eMemEn = 1'b1;
                    eMemAddr = {t, s, wk, 1'b0};
                end
                if (k >= 5 && k <= 12) begin
                    wk = 3'(k - 5);
                    eDw1 = (v == 0);
                    eDw2 = (v == 1);
                    ckWord = 1'b1;
                    eWordEn = 8'h01 << wk;
                    eDataIn = memFn({t, s, wk, 1'b0});
                end
                if (k == 13) begin
                    eMw1 = (v == 0);
                    eMw2 = (v == 1);
                    eMetaIn = {1'b1, 1'b0, t};
                end
                if (k == 14) begin
                    eMw1 = (o == 0);
                    eMw2 = (o == 1);
                    eMetaIn = {refV[o][s], 1'b1, refTag[o][s]};
                end
                tick("miss");
            end
            refV[v][s] = 1'b1;
            refTag[v][s] = t;
            refLru[v][s] = 1'b0;
            refLru[o][s] = 1'b1;
        end
    endtask

    task automatic idleCycle(input logic [15:0] a);
        req_valid = 1'b0;
        req_addr  = a;
        setIdle(a);
        tick("idle");
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0000; strayValid = 1'b0;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 64; s++) begin
                refV[w][s] = 1'b0; refLru[w][s] = 1'b0; refTag[w][s] = 6'd0;
            end
        @(posedge clk);
        #1;
        // Reset: all controls low, block_en follows the request set, word_en low
        for (int i = 0; i < 2; i++) begin
            setIdle(16'h0000);
            eWordEn = 8'h00;
            tick("reset");
        end
        rst = 1'b0;
        idleCycle(16'h1234);

        // Cold miss into way 1, replay hit, hit on another word of the line
        access(16'h1234, -1);
        checkLit("fill1_meta1", {8'h00, arrMeta1[6'h23]}, 16'h0084);
        checkLit("fill1_meta2", {8'h00, arrMeta2[6'h23]}, 16'h0040);
        checkLit("fill1_word0", arrData1[6'h23][0], 16'h6A2E);
        for (int w = 0; w < 8; w++)
            checkLit("fill1_data", arrData1[6'h23][w], memFn({6'h04, 6'h23, 3'(w), 1'b0}));
        access(16'h1234, -1);
        access(16'h1238, -1);
        idleCycle(16'h1238);

        // Same set, tag 5 -> way 2
        access(16'h1634, -1);
        checkLit("fill2_meta2", {8'h00, arrMeta2[6'h23]}, 16'h0085);
        checkLit("fill2_meta1", {8'h00, arrMeta1[6'h23]}, 16'h00C4);
        access(16'h1634, -1);

        // Tag 6 evicts way 1 (LRU), then tag 4 evicts way 2
        access(16'h1A34, -1);
        checkLit("fill3_meta1", {8'h00, arrMeta1[6'h23]}, 16'h0086);
        checkLit("fill3_meta2", {8'h00, arrMeta2[6'h23]}, 16'h00C5);
        access(16'h1A34, -1);
        access(16'h1634, -1);
        access(16'h1234, -1);
        checkLit("fill4_meta2", {8'h00, arrMeta2[6'h23]}, 16'h0084);
        checkLit("fill4_meta1", {8'h00, arrMeta1[6'h23]}, 16'h00C6);
        access(16'h1234, -1);

        // Hit on the LRU-marked way leaves metadata untouched
        access(16'h1A36, -1);
        idleCycle(16'h1A36);
        checkLit("lruhit_meta1", {8'h00, arrMeta1[6'h23]}, 16'h00C6);

        // Reset with three words received; late returns and stray valids are ignored
        access(16'h2468, 8);
        for (int i = 0; i < 5; i++) idleCycle(16'h2468);
        strayValid = 1'b1;
        idleCycle(16'h2468);
        idleCycle(16'h1234);
        strayValid = 1'b0;
        checkLit("abort_meta1", {8'h00, arrMeta1[6'h06]}, 16'h0000);
        checkLit("abort_meta2", {8'h00, arrMeta2[6'h06]}, 16'h0000);

        // The aborted line must refill from scratch
        access(16'h2468, -1);
        checkLit("refill_meta1", {8'h00, arrMeta1[6'h06]}, 16'h0089);
        access(16'h2468, -1);
        idleCycle(16'h0000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
